// File: rtl/ahbl_apb_bridge_n.sv
// AHB-Lite slave to APB4 master bridge with decoded slots, PREADY wait states, PSLVERR,
// PSTRB generation, unmapped-slot error and PREADY timeout.
module ahbl_apb_bridge_n #(
    parameter int unsigned NUM_SLAVES     = 8,
    parameter int unsigned SLV_SHIFT      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     hsel,
    input  logic [31:0]              haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic [31:0]              hwdata,
    input  logic                     hready,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic [31:0]              hrdata,
    output logic [31:0]              paddr,
    output logic                     pwrite,
    output logic [31:0]              pwdata,
    output logic [3:0]               pstrb,
    output logic [NUM_SLAVES-1:0]    psel,
    output logic                     penable,
    input  logic [32*NUM_SLAVES-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]    pready,
    input  logic [NUM_SLAVES-1:0]    pslverr
);
    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StAccess, StErr1, StErr2} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] slot_q;
    logic [31:0]      cnt_q;

    logic [IDX_W-1:0] addr_slot;
    logic             accept;
    logic             slot_ok;
    logic             cur_ready;
    logic             cur_err;
    logic [31:0]      cur_rdata;
    logic             timed_out;
    logic [3:0]       strb;
    logic             unused_htrans;

    assign addr_slot     = haddr[SLV_SHIFT +: IDX_W];
    assign accept        = hsel & htrans[1] & hready;
    assign slot_ok       = 32'(addr_slot) < NUM_SLAVES;
    assign cur_ready     = pready[slot_q];
    assign cur_err       = pslverr[slot_q];
    assign cur_rdata     = prdata[{slot_q, 5'b00000} +: 32];
    assign timed_out     = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign pwdata        = hwdata;
    assign unused_htrans = htrans[0];

    always_comb begin
        strb = 4'b1111;
        case (hsize)
            3'b000:  strb = 4'b0001 << haddr[1:0];
            3'b001:  strb = 4'b0011 << {haddr[1], 1'b0};
            default: strb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            slot_q    <= '0;
            cnt_q     <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pstrb     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StErr2: begin
                    if (accept) begin
                        hreadyout <= 1'b0;
                        if (slot_ok) begin
                            paddr   <= haddr;
                            pwrite  <= hwrite;
                            pstrb   <= hwrite ? strb : 4'b0000;
                            slot_q  <= addr_slot;
                            psel    <= NUM_SLAVES'(1) << addr_slot;
                            hresp   <= 1'b0;
                            state_q <= StSetup;
                        end else begin
                            // Unmapped slot: error response without touching APB
                            hresp   <= 1'b1;
                            state_q <= StErr1;
                        end
                    end else begin
                        hresp   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (cur_ready || timed_out) begin
                        psel    <= '0;
                        penable <= 1'b0;
                        cnt_q   <= '0;
                        if (cur_ready && !cur_err) begin
                            hreadyout <= 1'b1;
                            if (!pwrite) begin
                                hrdata <= cur_rdata;
                            end
                            state_q <= StIdle;
                        end else begin
                            hresp   <= 1'b1;
                            state_q <= StErr1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StErr1: begin
                    hreadyout <= 1'b1;
                    state_q   <= StErr2;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ahbl_apb_bridge_n.sv
// Scoreboard bench for ahbl_apb_bridge_n: AHB driver pushes expected responses, an AHB monitor
// and an APB slave model pop and compare independently.
module tb_ahbl_apb_bridge_n;
    localparam int NSL = 6;
    localparam int TMO = 8;

    typedef struct {
        logic [31:0] addr;
        bit          write;
        logic [31:0] wdata;
        int          waits;
        bit          slverr;
        logic [31:0] rdata;
        int          slot;
        bit          mapped;
        bit          err;
        logic [3:0]  strb;
        int          cycles;
        logic [31:0] exp_hrdata;
    } xfer_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic              hsel;
    logic [31:0]       haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [31:0]       hrdata;
    logic [31:0]       paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [NSL-1:0]    psel;
    logic              penable;
    logic [32*NSL-1:0] prdata;
    logic [NSL-1:0]    pready;
    logic [NSL-1:0]    pslverr;

    int          n_cmp = 0;
    int          n_err = 0;
    xfer_t       sb_q[$];
    xfer_t       apb_q[$];
    logic [31:0] model_hrdata = 32'h0;

    always #5 clk = ~clk;

    ahbl_apb_bridge_n #(
        .NUM_SLAVES    (NSL),
        .SLV_SHIFT     (12),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hwdata   (hwdata),
        .hready   (hreadyout),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .paddr    (paddr),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one NONSEQ transfer; returns one cycle after its address phase was accepted.
    task automatic issue(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                         input logic [31:0] wdata, input int waits, input bit slverr,
                         input logic [31:0] rdata);
        xfer_t x;
        int    nbytes;
        int    off;
        int    budget;
        bit    acc;
        x.addr   = addr;
        x.write  = wr;
        x.wdata  = wdata;
        x.waits  = waits;
        x.slverr = slverr;
        x.rdata  = rdata;
        x.slot   = int'((addr >> 12) % 8);
        x.mapped = x.slot < NSL;
        nbytes   = (size > 3'd2) ? 4 : (1 << size);
        off      = (int'(addr % 4) / nbytes) * nbytes;
        x.strb   = wr ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
        x.err    = !x.mapped || waits >= TMO || slverr;
        if (!x.mapped)        x.cycles = 2;
        else if (waits >= TMO) x.cycles = TMO + 3;
        else if (slverr)      x.cycles = waits + 4;
        else                  x.cycles = waits + 3;
        if (!x.err && !wr) model_hrdata = rdata;
        x.exp_hrdata = model_hrdata;

        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        budget = 0;
        acc    = 1'b0;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = hreadyout;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept: hreadyout stuck %b, expected 1 within 100 cycles", hreadyout);
        end else begin
            sb_q.push_back(x);
            if (x.mapped) apb_q.push_back(x);
            hwdata = wdata;
        end
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // AHB monitor: closes a data phase on the first hreadyout=1 cycle after acceptance.
    initial begin : ahb_monitor
        bit    in_data;
        int    cyc;
        logic  prev_hresp;
        xfer_t x;
        in_data    = 1'b0;
        cyc        = 0;
        prev_hresp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                in_data = 1'b0;
            end else begin
                if (in_data) begin
                    cyc++;
                    if (hreadyout) begin
                        in_data = 1'b0;
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL sb_empty: got completion, expected none");
                        end else begin
                            x = sb_q.pop_front();
                            chk("hresp_2cyc", {30'b0, prev_hresp, hresp}, x.err ? 32'd3 : 32'd0);
                            chk("latency", 32'(cyc), 32'(x.cycles));
                            chk("hrdata", hrdata, x.exp_hrdata);
                        end
                    end else if (cyc > 60) begin
                        in_data = 1'b0;
                        n_cmp++;
                        n_err++;
                        $display("FAIL data_phase: got %0d wait cycles, expected <= 60", cyc);
                        if (sb_q.size() != 0) x = sb_q.pop_front();
                    end
                end
                if (hsel && htrans[1] && hreadyout) begin
                    in_data = 1'b1;
                    cyc     = 0;
                end
            end
            prev_hresp = hresp;
        end
    end

    // APB slave model: checks the access on its first ACCESS cycle, then inserts wait states.
    initial begin : apb_slave
        bit    active;
        int    n;
        xfer_t cur;
        active  = 1'b0;
        n       = 0;
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        forever begin
            @(negedge clk);
            if (rstn && psel != '0 && penable) begin
                if (!active) begin
                    active = 1'b1;
                    n      = 0;
                    if (apb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL apb_spurious: got psel=%b, expected no access", psel);
                        cur.slot   = 0;
                        cur.waits  = 0;
                        cur.slverr = 1'b0;
                        cur.rdata  = 32'h0;
                    end else begin
                        cur = apb_q.pop_front();
                        chk("psel", 32'(psel), 32'(1) << cur.slot);
                        chk("paddr", paddr, cur.addr);
                        chk("pwrite", 32'(pwrite), 32'(cur.write));
                        chk("pstrb", 32'(pstrb), 32'(cur.strb));
                        if (cur.write) chk("pwdata", pwdata, cur.wdata);
                    end
                end else begin
                    n++;
                end
                for (int i = 0; i < NSL; i++) prdata[32*i +: 32] = $urandom;
                if (n == cur.waits) begin
                    pready  = NSL'(1) << cur.slot;
                    pslverr = cur.slverr ? (NSL'(1) << cur.slot) : '0;
                    prdata[32*cur.slot +: 32] = cur.rdata;
                end else begin
                    pready  = '0;
                    pslverr = '0;
                end
            end else begin
                active  = 1'b0;
                pready  = '0;
                pslverr = '0;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        int          w;
        int          budget;
        rstn   = 1'b0;
        hsel   = 1'b0;
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hwdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_hrdata", hrdata, 32'h0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        rstn = 1'b1;
        idle(2);

        issue(32'h0000_1004, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        idle(4);
        issue(32'h0000_3000, 1'b0, 3'd2, 32'h0, 4, 1'b0, 32'h1234_5678);
        idle(1);
        issue(32'h0000_2003, 1'b1, 3'd0, 32'hAA00_0000, 0, 1'b0, 32'h0);
        issue(32'h0000_2002, 1'b1, 3'd1, 32'hBBBB_0000, 1, 1'b0, 32'h0);
        issue(32'h0000_4000, 1'b1, 3'd2, 32'h0BAD_0BAD, 0, 1'b1, 32'h0);
        issue(32'h0000_7000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0);
        issue(32'h0000_6010, 1'b1, 3'd2, 32'h0, 0, 1'b0, 32'h0);
        issue(32'h0000_5000, 1'b0, 3'd2, 32'h0, 100, 1'b0, 32'hFFFF_FFFF);
        issue(32'h0000_0008, 1'b0, 3'd2, 32'h0, 7, 1'b0, 32'hCAFE_F00D);
        issue(32'h0000_5004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h5555_AAAA);

        for (int i = 0; i < 60; i++) begin
            a = {$urandom_range(0, 32'h1_FFFF), 3'($urandom_range(0, 7)), 12'($urandom)};
            w = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
            issue(a, 1'($urandom), 3'($urandom_range(0, 3)), $urandom, w,
                  $urandom_range(0, 5) == 0, $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of an ACCESS phase aborts the transfer
        issue(32'h0000_2000, 1'b0, 3'd2, 32'h0, 6, 1'b0, 32'h1111_2222);
        idle(3);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_psel", 32'(psel), 32'd0);
        chk("abort_penable", 32'(penable), 32'd0);
        chk("abort_hreadyout", 32'(hreadyout), 32'd1);
        chk("abort_hresp", 32'(hresp), 32'd0);
        sb_q.delete();
        apb_q.delete();
        model_hrdata = 32'h0;
        rstn = 1'b1;
        idle(1);
        issue(32'h0000_1000, 1'b0, 3'd2, 32'h0, 2, 1'b0, 32'h7777_8888);

        budget = 0;
        while (sb_q.size() != 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
